matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//   Controller for the 3x3 array-multiply datapath. Waits for the input buffer to report
//   all 18 operand bytes stored (A row-major at 0..8, B row-major at 9..17), then reads
//   operand pairs and accumulates in an internal MAC to form C = A*B.
//   Streams each 18-bit C element out as 3 bytes over a valid/ready handshake.
// PARAMETERS
//   N     3   matrix dimension (square N x N operands)
//   DW    8   operand width, bits
//   ACCW  18  accumulator width = 2*DW + clog2(N); must hold N*(2^DW-1)^2
//   AW    5   buffer address width = clog2(2*N*N)
// PORTS
//   clk         in   1    system clock
//   reset       in   1    asynchronous, active-low reset
//   buf_done    in   1    input buffer full flag (level, held high until reset)
//   buf_a_addr  out  AW   A read address = i*N+k (combinational from counters)
//   buf_b_addr  out  AW   B read address = N*N+k*N+j
//   buf_a_data  in   DW   stored byte at buf_a_addr, same-cycle (combinational) read
//   buf_b_data  in   DW   stored byte at buf_b_addr, same-cycle read
//   out_data    out  8    current result byte
//   out_valid   out  1    out_data valid
//   out_ready   in   1    sink accepts byte when out_valid && out_ready
//   busy        out  1    high in any state other than IDLE
//   frame_done  out  1    one-cycle pulse after last byte of C[N-1][N-1] accepted
// BEHAVIOUR
//   - Clock is clk. Reset is asynchronous and active-low on port reset.
//   - Reset (async): state=IDLE; i,j,k,byte_sel,acc,done_q=0.
//     All outputs 0: addresses 0, out_data 0, out_valid 0, busy 0, frame_done 0.
//   - Start: done_q <= buf_done every cycle. In IDLE, buf_done && !done_q (rising edge)
//     -> MAC next cycle with i=j=k=0.
//     A rising edge while busy is dropped, not queued. buf_done held high never restarts.
//   - FSM IDLE -> MAC -> SEND -> (MAC | IDLE).
//   - MAC, one cycle per k:
//     acc <= (k==0 ? 0 : acc) + buf_a_data*buf_b_data (zero-extended to ACCW).
//     k==N-1 -> SEND, byte_sel=0, k=0. Addresses are 0 outside MAC.
//   - SEND: out_valid=1, out_data = byte_sel 0: acc[7:0], 1: acc[15:8],
//     2: {6'b0,acc[17:16]} (little-endian).
//     Advance byte_sel only on out_valid&&out_ready.
//     With out_ready low, out_data/out_valid/acc stay stable.
//   - Accept of byte 2: if (i,j)==(N-1,N-1) -> IDLE, frame_done=1 for that next cycle;
//     else j++ (wrap to 0 with i++) -> MAC.
//   - Order: i outer, j middle, k inner; elements emitted C[0][0],C[0][1],...,C[N-1][N-1].
//   - Latency: first out_valid N+1 cycles after the edge-sampling cycle.
//     Each element takes N+3 cycles with out_ready=1; full frame 9*(N+3)=54 cycles.
//   - No overflow: ACCW is sized for the worst case, so there is no wrap/saturation logic.
//   - Reset mid-frame aborts immediately with no frame_done. A restart needs a fresh
//     buf_done rising edge; the buffer shares the reset, so buf_done returns low.
// STRUCTURE
//   - Shared package matmul_pkg: N, DW, ACCW, AW, base address of B (N*N),
//     state encoding (IDLE, MAC, SEND).
//   - One sub-module mac_unit (DW x DW multiply, ACCW accumulate, clr/en inputs).
//     FSM, counters and byte serializer stay in matmul_sequencer.
// TESTING
//   1. A=identity, B=1..9 -> 27 bytes: 01 00 00, 02 00 00, ..., 09 00 00; one frame_done.
//   2. A,B all 0xFF -> every element 195075 = bytes 03 FA 02.
//      Checks acc MSBs and absence of overflow.
//   3. A all 0 except A[2][0]=7, B all 0 except B[0][1]=3 -> only element index 7
//      (i=2,j=1) = 21 = bytes 15 00 00; all others 00 00 00.
//   4. out_ready low for 5 cycles while byte_sel=1 -> out_data/out_valid constant.
//      Resumes with byte 2, no byte lost or duplicated.
//   5. buf_done held high after frame_done for 100 cycles -> busy stays 0.
//      Pulse buf_done low then high -> a second identical frame.
//   6. Assert reset during SEND of element 4 -> all outputs 0 asynchronously.
//      After release with buf_done high -> no activity until a fresh buf_done rising edge.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared parameters and state encoding for the 3x3 matrix-multiply sequencer.
package matmul_pkg;
   localparam int unsigned N      = 3;
   localparam int unsigned DW     = 8;
   localparam int unsigned ACCW   = 2 * DW + $clog2(N);
   localparam int unsigned AW     = $clog2(2 * N * N);
   localparam int unsigned B_BASE = N * N;
   localparam int unsigned CW     = $clog2(N);
   localparam int unsigned BSW    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_SEND = 2'd2
   } state_t;
endpackage

// File: rtl/matmul_sequencer_if.sv
// Operand-buffer read port, result byte stream and status flags of the sequencer.
interface matmul_sequencer_if;
   import matmul_pkg::*;

   logic          buf_done;
   logic [AW-1:0] buf_a_addr;
   logic [AW-1:0] buf_b_addr;
   logic [DW-1:0] buf_a_data;
   logic [DW-1:0] buf_b_data;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          frame_done;

   modport master (
      input  buf_done, buf_a_data, buf_b_data, out_ready,
      output buf_a_addr, buf_b_addr, out_data, out_valid, busy, frame_done
   );

   modport slave (
      output buf_done, buf_a_data, buf_b_data, out_ready,
      input  buf_a_addr, buf_b_addr, out_data, out_valid, busy, frame_done
   );
endinterface

// File: rtl/matmul_sequencer_mac_unit.sv
// Multiply-accumulate for one C element; clr restarts the sum with the current product.
module mac_unit
   import matmul_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            en,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [ACCW-1:0] acc
);
   logic [ACCW-1:0] prod_c;

   assign prod_c = ACCW'(a) * ACCW'(b);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  acc <= '0;
      else if (en) acc <= (clr ? '0 : acc) + prod_c;
   end
endmodule

// File: rtl/matmul_sequencer.sv
// Sequences C = A*B over a shared operand buffer and streams each 18-bit element as 3 bytes.
module matmul_sequencer
   import matmul_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   matmul_sequencer_if.master bus
);
   state_t          state_q, state_d;
   logic [CW-1:0]   i_q, j_q, k_q;
   logic [BSW-1:0]  byte_sel_q;
   logic            done_q;
   logic            frame_done_q;
   logic [ACCW-1:0] acc;
   logic            start_c, last_k_c, last_byte_c, last_elem_c, accept_c;
   logic            mac_en_c, mac_clr_c;

   // Only a fresh rising edge of buf_done starts a frame; a level held high never restarts.
   assign start_c     = bus.buf_done && !done_q;
   assign last_k_c    = (k_q == CW'(N - 1));
   assign last_byte_c = (byte_sel_q == BSW'(2));
   assign last_elem_c = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
   assign accept_c    = (state_q == ST_SEND) && bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_c) state_d = ST_MAC;
         ST_MAC:  if (last_k_c) state_d = ST_SEND;
         ST_SEND: if (accept_c && last_byte_c) state_d = last_elem_c ? ST_IDLE : ST_MAC;
         default: state_d = ST_IDLE;
      endcase
   end

   // Loop counters (i outer, j middle, k inner), byte selector and status flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_q          <= '0;
         j_q          <= '0;
         k_q          <= '0;
         byte_sel_q   <= '0;
         done_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         done_q       <= bus.buf_done;
         frame_done_q <= accept_c && last_byte_c && last_elem_c;
         case (state_q)
            ST_IDLE: begin
               if (start_c) begin
                  i_q        <= '0;
                  j_q        <= '0;
                  k_q        <= '0;
                  byte_sel_q <= '0;
               end
            end
            ST_MAC: begin
               k_q <= last_k_c ? '0 : k_q + CW'(1);
               if (last_k_c) byte_sel_q <= '0;
            end
            ST_SEND: begin
               if (accept_c) begin
                  if (last_byte_c) begin
                     byte_sel_q <= '0;
                     if (j_q == CW'(N - 1)) begin
                        j_q <= '0;
                        i_q <= (i_q == CW'(N - 1)) ? '0 : i_q + CW'(1);
                     end else begin
                        j_q <= j_q + CW'(1);
                     end
                  end else begin
                     byte_sel_q <= byte_sel_q + BSW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.buf_a_addr = '0;
      bus.buf_b_addr = '0;
      bus.out_data   = '0;
      bus.out_valid  = 1'b0;
      bus.busy       = (state_q != ST_IDLE);
      bus.frame_done = frame_done_q;
      mac_en_c       = 1'b0;
      mac_clr_c      = 1'b0;
      case (state_q)
         ST_MAC: begin
            bus.buf_a_addr = AW'(i_q) * AW'(N) + AW'(k_q);
            bus.buf_b_addr = AW'(B_BASE) + AW'(k_q) * AW'(N) + AW'(j_q);
            mac_en_c       = 1'b1;
            mac_clr_c      = (k_q == '0);
         end
         ST_SEND: begin
            bus.out_valid = 1'b1;
            case (byte_sel_q)
               BSW'(0): bus.out_data = acc[7:0];
               BSW'(1): bus.out_data = acc[15:8];
               BSW'(2): bus.out_data = 8'(acc[ACCW-1:16]);
               default: bus.out_data = '0;
            endcase
         end
         default: ;
      endcase
   end

   mac_unit u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr_c),
      .en    (mac_en_c),
      .a     (bus.buf_a_data),
      .b     (bus.buf_b_data),
      .acc   (acc)
   );
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: operand buffer model, reference C = A*B, stall and reset scenarios.
module tb_matmul_sequencer;
   import matmul_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matmul_sequencer_if bus ();

   matmul_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [0:17];
   int         a_m [9];
   int         b_m [9];
   logic [7:0] sb [$];
   int         checks = 0;
   int         errors = 0;

   assign bus.buf_a_data = (bus.buf_a_addr < 5'd18) ? mem[bus.buf_a_addr] : 8'h00;
   assign bus.buf_b_data = (bus.buf_b_addr < 5'd18) ? mem[bus.buf_b_addr] : 8'h00;

   // Fill the buffer from a_m/b_m and queue the expected little-endian bytes of each C element.
   task automatic load_frame();
      for (int n = 0; n < 9; n++) begin
         mem[n]     = 8'(a_m[n]);
         mem[n + 9] = 8'(b_m[n]);
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            int unsigned c;
            logic [17:0] cv;
            c = 0;
            for (int k = 0; k < 3; k++) c += a_m[i*3+k] * b_m[k*3+j];
            cv = 18'(c);
            sb.push_back(cv[7:0]);
            sb.push_back(cv[15:8]);
            sb.push_back(8'(cv[17:16]));
         end
      end
   endtask

   task automatic run_frame(input string tag, input int stall_at, input int exp_fd);
      int         cyc = 0;
      int         got = 0;
      int         first_v = -1;
      int         fd_cyc = -1;
      int         stall_left = 0;
      int         busy_low = 0;
      bit         stalled = 1'b0;
      logic [7:0] hold = 8'h00;
      logic [7:0] exp;
      bus.out_ready = 1'b1;
      bus.buf_done  = 1'b0;
      @(negedge clk);
      bus.buf_done = 1'b1;
      while (fd_cyc < 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.frame_done === 1'b1) begin
            fd_cyc = cyc;
         end else begin
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.out_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (stall_left > 0) begin
               checks++;
               if (bus.out_valid !== 1'b1 || bus.out_data !== hold) begin
                  errors++;
                  $display("FAIL %s stall_hold cyc %0d: valid %b data %02h, required valid 1 data %02h",
                           tag, cyc, bus.out_valid, bus.out_data, hold);
               end
               stall_left--;
               if (stall_left == 0) bus.out_ready = 1'b1;
            end else if (!stalled && stall_at >= 0 && got == stall_at && bus.out_valid === 1'b1) begin
               stalled       = 1'b1;
               hold          = bus.out_data;
               bus.out_ready = 1'b0;
               stall_left    = 5;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL %s extra_byte %0d: got %02h, required no byte", tag, got, bus.out_data);
               end else begin
                  exp = sb.pop_front();
                  if (bus.out_data !== exp) begin
                     errors++;
                     $display("FAIL %s byte %0d: got %02h, required %02h", tag, got, bus.out_data, exp);
                  end
               end
               got++;
            end
         end
      end
      checks++;
      if (fd_cyc != exp_fd) begin
         errors++;
         $display("FAIL %s frame_done_cycle: got %0d, required %0d", tag, fd_cyc, exp_fd);
      end
      checks++;
      if (first_v != 4) begin
         errors++;
         $display("FAIL %s first_valid_latency: got %0d, required 4", tag, first_v);
      end
      checks++;
      if (got != 27 || sb.size() != 0) begin
         errors++;
         $display("FAIL %s byte_count: got %0d left %0d, required 27 left 0", tag, got, sb.size());
      end
      checks++;
      if (busy_low != 0) begin
         errors++;
         $display("FAIL %s busy_in_frame: got %0d low cycles, required 0", tag, busy_low);
      end
      @(negedge clk);
      checks++;
      if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_frame: frame_done %b busy %b, required 0 0", tag, bus.frame_done, bus.busy);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s flags: valid %b busy %b frame_done %b, required 0 0 0",
                  tag, bus.out_valid, bus.busy, bus.frame_done);
      end
      checks++;
      if (bus.out_data !== 8'h00 || bus.buf_a_addr !== 5'd0 || bus.buf_b_addr !== 5'd0) begin
         errors++;
         $display("FAIL %s values: data %02h a_addr %0d b_addr %0d, required 00 0 0",
                  tag, bus.out_data, bus.buf_a_addr, bus.buf_b_addr);
      end
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.buf_done  = 1'b0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 18; n++) mem[n] = 8'h00;
      #12;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      for (int n = 0; n < 9; n++) begin
         a_m[n] = (n % 4 == 0) ? 1 : 0;
         b_m[n] = n + 1;
      end
      load_frame();
      run_frame("identity", -1, 55);
   endtask

   task automatic test_all_ff();
      for (int n = 0; n < 9; n++) begin
         a_m[n] = 255;
         b_m[n] = 255;
      end
      load_frame();
      run_frame("all_ff", -1, 55);
   endtask

   task automatic test_sparse();
      for (int n = 0; n < 9; n++) begin
         a_m[n] = 0;
         b_m[n] = 0;
      end
      a_m[6] = 7;
      b_m[1] = 3;
      load_frame();
      run_frame("sparse", -1, 55);
   endtask

   task automatic test_stall();
      for (int n = 0; n < 9; n++) begin
         a_m[n] = 17 * n + 40;
         b_m[n] = 250 - 9 * n;
      end
      load_frame();
      run_frame("stall", 7, 60);
   endtask

   task automatic test_hold_restart();
      int busy_hi = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) busy_hi++;
      end
      checks++;
      if (busy_hi != 0) begin
         errors++;
         $display("FAIL hold_no_restart: got %0d busy cycles, required 0", busy_hi);
      end
      load_frame();
      run_frame("restart", -1, 55);
   endtask

   task automatic test_reset_mid();
      int busy_hi = 0;
      for (int n = 0; n < 9; n++) begin
         a_m[n] = n + 1;
         b_m[n] = 9 - n;
      end
      load_frame();
      bus.out_ready = 1'b1;
      bus.buf_done  = 1'b0;
      @(negedge clk);
      bus.buf_done = 1'b1;
      repeat (28) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_send_valid: got %b, required 1", bus.out_valid);
      end
      #2;
      reset        = 1'b0;
      bus.buf_done = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) busy_hi++;
      end
      checks++;
      if (busy_hi != 0) begin
         errors++;
         $display("FAIL post_reset_quiet: got %0d active cycles, required 0", busy_hi);
      end
      load_frame();
      run_frame("post_reset", -1, 55);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_all_ff();
      test_sparse();
      test_stall();
      test_hold_restart();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
